// File: rtl/lap_tracker.sv
// Race-progress monitor: enforces in-order checkpoint passage, times laps in
// centiseconds and flags finish-line crossings and lap timeouts for main_fsm.
module lap_tracker #(
  parameter int CS_DIV     = 650000,
  parameter int MAX_LAP_CS = 6000,
  parameter int ZONE_HALF  = 40,
  parameter int FIN_X      = 512,
  parameter int FIN_Y      = 700,
  parameter int CP1_X      = 900,
  parameter int CP1_Y      = 400,
  parameter int CP2_X      = 512,
  parameter int CP2_Y      = 100,
  parameter int CP3_X      = 120,
  parameter int CP3_Y      = 400
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [10:0] car_xpos,
  input  logic [10:0] car_ypos,
  output logic        lap_finished,
  output logic        checkpoints_passed,
  output logic        max_lap_time_exceeded,
  output logic [3:0]  lap_count,
  output logic [13:0] lap_time_cs,
  output logic [13:0] last_lap_cs,
  output logic [13:0] best_lap_cs,
  output logic [1:0]  cp_progress
);

  localparam int DIV_W = (CS_DIV > 1) ? $clog2(CS_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CS_DIV - 1);
  localparam logic [13:0] MAX_CS = 14'(MAX_LAP_CS);
  localparam logic signed [12:0] HALF = 13'(ZONE_HALF);

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, RACING = 2'd2} state_e;

  function automatic logic in_zone(input logic [10:0] px, input logic [10:0] py,
                                   input logic signed [12:0] cx,
                                   input logic signed [12:0] cy);
    logic signed [12:0] dx;
    logic signed [12:0] dy;
    dx = $signed({2'b00, px}) - cx;
    dy = $signed({2'b00, py}) - cy;
    in_zone = (dx <= HALF) && (dx >= -HALF) && (dy <= HALF) && (dy >= -HALF);
  endfunction

  state_e           state_q, state_d;
  logic [1:0]       cp_idx_q, cp_idx_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [13:0]      lap_time_q, lap_time_d;
  logic [13:0]      last_q, last_d;
  logic [13:0]      best_q, best_d;
  logic [3:0]       lap_count_q, lap_count_d;
  logic             in_fin_q, in_fin_d;
  logic             lap_fin_q, lap_fin_d;
  logic             tout_q, tout_d;
  logic             cp_passed_q, cp_passed_d;

  logic in_fin, in_cp1, in_cp2, in_cp3, fin_entry, div_wrap;

  assign in_fin    = in_zone(car_xpos, car_ypos, 13'(FIN_X), 13'(FIN_Y));
  assign in_cp1    = in_zone(car_xpos, car_ypos, 13'(CP1_X), 13'(CP1_Y));
  assign in_cp2    = in_zone(car_xpos, car_ypos, 13'(CP2_X), 13'(CP2_Y));
  assign in_cp3    = in_zone(car_xpos, car_ypos, 13'(CP3_X), 13'(CP3_Y));
  assign fin_entry = in_fin & ~in_fin_q;
  assign div_wrap  = (div_q == DIV_LAST);

  // Next-state, lap statistics and pulse generation.
  always_comb begin
    state_d     = state_q;
    cp_idx_d    = cp_idx_q;
    div_d       = div_q;
    lap_time_d  = lap_time_q;
    last_d      = last_q;
    best_d      = best_q;
    lap_count_d = lap_count_q;
    in_fin_d    = in_fin;
    lap_fin_d   = 1'b0;
    tout_d      = 1'b0;
    cp_passed_d = (cp_idx_q == 2'd3);

    if (!enable) begin
      state_d     = IDLE;
      cp_idx_d    = 2'd0;
      div_d       = '0;
      lap_time_d  = 14'd0;
      last_d      = 14'd0;
      best_d      = 14'd0;
      lap_count_d = 4'd0;
      in_fin_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = ARMED;
        end
        ARMED: begin
          if (fin_entry) begin
            state_d    = RACING;
            lap_time_d = 14'd0;
            div_d      = '0;
            cp_idx_d   = 2'd0;
          end else begin
            state_d = ARMED;
          end
        end
        RACING: begin
          div_d = div_wrap ? '0 : div_q + DIV_W'(1);
          // Timeout outranks a finish crossing on the same edge.
          if (div_wrap && (lap_time_q == MAX_CS)) begin
            tout_d     = 1'b1;
            state_d    = ARMED;
            lap_time_d = 14'd0;
            cp_idx_d   = 2'd0;
            div_d      = '0;
          end else if (fin_entry) begin
            lap_fin_d  = 1'b1;
            cp_idx_d   = 2'd0;
            lap_time_d = 14'd0;
            div_d      = '0;
            if (cp_idx_q == 2'd3) begin
              last_d      = lap_time_q;
              lap_count_d = (lap_count_q == 4'd15) ? 4'd15 : lap_count_q + 4'd1;
              if ((best_q == 14'd0) || (lap_time_q < best_q)) begin
                best_d = lap_time_q;
              end else begin
                best_d = best_q;
              end
            end else begin
              last_d = last_q;
            end
          end else begin
            if (div_wrap) begin
              lap_time_d = lap_time_q + 14'd1;
            end else begin
              lap_time_d = lap_time_q;
            end
            case (cp_idx_q)
              2'd0:    cp_idx_d = in_cp1 ? 2'd1 : 2'd0;
              2'd1:    cp_idx_d = in_cp2 ? 2'd2 : 2'd1;
              2'd2:    cp_idx_d = in_cp3 ? 2'd3 : 2'd2;
              default: cp_idx_d = 2'd3;
            endcase
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cp_idx_q    <= 2'd0;
      div_q       <= '0;
      lap_time_q  <= 14'd0;
      last_q      <= 14'd0;
      best_q      <= 14'd0;
      lap_count_q <= 4'd0;
      in_fin_q    <= 1'b0;
      lap_fin_q   <= 1'b0;
      tout_q      <= 1'b0;
      cp_passed_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cp_idx_q    <= cp_idx_d;
      div_q       <= div_d;
      lap_time_q  <= lap_time_d;
      last_q      <= last_d;
      best_q      <= best_d;
      lap_count_q <= lap_count_d;
      in_fin_q    <= in_fin_d;
      lap_fin_q   <= lap_fin_d;
      tout_q      <= tout_d;
      cp_passed_q <= cp_passed_d;
    end
  end

  assign lap_finished          = lap_fin_q;
  assign checkpoints_passed    = cp_passed_q;
  assign max_lap_time_exceeded = tout_q;
  assign lap_count             = lap_count_q;
  assign lap_time_cs           = lap_time_q;
  assign last_lap_cs           = last_q;
  assign best_lap_cs           = best_q;
  assign cp_progress           = cp_idx_q;

endmodule

// File: tb/tb_lap_tracker.sv
// Directed bench for lap_tracker with a short centisecond (4 clocks) and a
// 50 cs lap limit; expected values are hand-computed constants.
module tb_lap_tracker;

  logic        pclk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b0;
  logic [10:0] car_xpos = 11'd512;
  logic [10:0] car_ypos = 11'd700;
  logic        lap_finished, checkpoints_passed, max_lap_time_exceeded;
  logic [3:0]  lap_count;
  logic [13:0] lap_time_cs, last_lap_cs, best_lap_cs;
  logic [1:0]  cp_progress;

  int n_checks = 0;
  int n_fail = 0;

  lap_tracker #(.CS_DIV(4), .MAX_LAP_CS(50)) dut (
    .pclk(pclk), .rst_n(rst_n), .enable(enable),
    .car_xpos(car_xpos), .car_ypos(car_ypos),
    .lap_finished(lap_finished), .checkpoints_passed(checkpoints_passed),
    .max_lap_time_exceeded(max_lap_time_exceeded), .lap_count(lap_count),
    .lap_time_cs(lap_time_cs), .last_lap_cs(last_lap_cs),
    .best_lap_cs(best_lap_cs), .cp_progress(cp_progress)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic move(input int x, input int y);
    car_xpos = 11'(x);
    car_ypos = 11'(y);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_lapfin"}, 32'(lap_finished), 32'd0);
    check({tag, "_cppass"}, 32'(checkpoints_passed), 32'd0);
    check({tag, "_tout"}, 32'(max_lap_time_exceeded), 32'd0);
    check({tag, "_count"}, 32'(lap_count), 32'd0);
    check({tag, "_time"}, 32'(lap_time_cs), 32'd0);
    check({tag, "_last"}, 32'(last_lap_cs), 32'd0);
    check({tag, "_best"}, 32'(best_lap_cs), 32'd0);
    check({tag, "_cp"}, 32'(cp_progress), 32'd0);
  endtask

  task automatic wait_lap_time(input int target);
    int k;
    k = 0;
    while ((int'(lap_time_cs) != target) && (k < 400)) begin
      @(negedge pclk);
      k++;
    end
    check("reach_lap_time", 32'(lap_time_cs), 32'(target));
  endtask

  // Drive one lap starting with the car on the finish line; finish at target cs.
  task automatic run_lap(input string tag, input int target, input bit valid,
                         input int exp_count, input int exp_last, input int exp_best);
    if (valid) begin
      move(900, 400); step(1);
      move(512, 100); step(1);
      move(120, 400); step(1);
    end else begin
      move(512, 100); step(1);
      move(900, 400); step(1);
    end
    move(300, 300); step(1);
    check({tag, "_cp_before_fin"}, 32'(cp_progress), valid ? 32'd3 : 32'd1);
    wait_lap_time(target);
    move(512, 700); step(1);
    check({tag, "_lapfin"}, 32'(lap_finished), 32'd1);
    check({tag, "_cppass"}, 32'(checkpoints_passed), valid ? 32'd1 : 32'd0);
    check({tag, "_count"}, 32'(lap_count), 32'(exp_count));
    check({tag, "_last"}, 32'(last_lap_cs), 32'(exp_last));
    check({tag, "_best"}, 32'(best_lap_cs), 32'(exp_best));
    check({tag, "_cp"}, 32'(cp_progress), 32'd0);
    check({tag, "_time"}, 32'(lap_time_cs), 32'd0);
    step(1);
    check({tag, "_lapfin_end"}, 32'(lap_finished), 32'd0);
    check({tag, "_cppass_end"}, 32'(checkpoints_passed), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #2 rst_n = 1'b0;
    step(2);
    check_zero("reset");
    rst_n = 1'b1;
    step(2);

    // Car parked on the line when enabled: no start.
    enable = 1'b1;
    step(9);
    check("parked_no_start", 32'(lap_time_cs), 32'd0);
    move(300, 300); step(1);
    move(553, 700); step(8);
    check("edge_outside_no_start", 32'(lap_time_cs), 32'd0);
    move(552, 740); step(1);
    check("start_no_pulse", 32'(lap_finished), 32'd0);
    step(4);
    check("inclusive_edge_start", 32'(lap_time_cs), 32'd1);

    run_lap("lap1", 30, 1'b1, 1, 30, 30);
    run_lap("lap2", 20, 1'b1, 2, 20, 20);
    run_lap("lap3", 40, 1'b1, 3, 40, 20);
    run_lap("bad", 15, 1'b0, 3, 40, 20);

    // Timeout after 50 cs in RACING.
    move(900, 400); step(1);
    move(300, 300); step(1);
    check("to_cp_before", 32'(cp_progress), 32'd1);
    wait_lap_time(50);
    step(3);
    check("to_early", 32'(max_lap_time_exceeded), 32'd0);
    step(1);
    check("to_pulse", 32'(max_lap_time_exceeded), 32'd1);
    check("to_time", 32'(lap_time_cs), 32'd0);
    check("to_cp", 32'(cp_progress), 32'd0);
    check("to_count", 32'(lap_count), 32'd3);
    step(1);
    check("to_pulse_end", 32'(max_lap_time_exceeded), 32'd0);
    step(8);
    check("armed_time_hold", 32'(lap_time_cs), 32'd0);
    move(512, 700); step(1);
    check("armed_restart_no_pulse", 32'(lap_finished), 32'd0);
    step(4);
    check("armed_restart_racing", 32'(lap_time_cs), 32'd1);

    // Timeout and finish entry on the same edge.
    move(300, 300); step(1);
    wait_lap_time(50);
    step(3);
    move(512, 700); step(1);
    check("coinc_tout", 32'(max_lap_time_exceeded), 32'd1);
    check("coinc_no_lapfin", 32'(lap_finished), 32'd0);
    check("coinc_count", 32'(lap_count), 32'd3);
    step(1);
    check("coinc_after_lapfin", 32'(lap_finished), 32'd0);

    // Restart, then drop enable mid-race.
    move(300, 300); step(1);
    move(512, 700); step(1);
    move(900, 400); step(1);
    check("pre_disable_cp", 32'(cp_progress), 32'd1);
    enable = 1'b0;
    step(1);
    check("dis_count", 32'(lap_count), 32'd0);
    check("dis_last", 32'(last_lap_cs), 32'd0);
    check("dis_best", 32'(best_lap_cs), 32'd0);
    check("dis_time", 32'(lap_time_cs), 32'd0);
    check("dis_cp", 32'(cp_progress), 32'd0);

    // Async reset mid-RACING with cp_idx = 2.
    enable = 1'b1;
    step(1);
    move(512, 700); step(1);
    run_lap("lap_r", 10, 1'b1, 1, 10, 10);
    move(900, 400); step(1);
    move(512, 100); step(1);
    move(300, 300); step(2);
    check("pre_reset_cp", 32'(cp_progress), 32'd2);
    check("pre_reset_count", 32'(lap_count), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    step(1);
    rst_n = 1'b1;
    step(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
